// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch sequencer: PC owner, ROM address driver and {pc, instr} FIFO toward decode
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_rdata,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic valid, full, pop, push;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = valid & inst_ready;
    assign push  = fetch_en & ~redirect_valid & (~full | pop);

    // rom_addr comes straight from the PC flop, so inst_ready never reaches it combinationally
    assign rom_addr   = pc_q;
    assign inst_valid = valid;
    assign inst       = valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign inst_pc    = valid ? pc_mem[rd_ptr_q]    : 32'h0;
    assign count      = count_q;

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                pc_d     = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked by valid and the pointers restart at zero
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            instr_mem[wr_ptr_q] <= rom_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, fetch_en, inst_ready, redirect_valid;
    logic [31:0] redirect_pc, rom_addr, rom_rdata, inst, inst_pc;
    logic        inst_valid;
    logic [1:0]  count;

    logic        rst_w, fen_w, ready_w;
    logic [31:0] rom_addr_w, rom_rdata_w, inst_w, inst_pc_w;
    logic        inst_valid_w;
    logic [1:0]  count_w;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q [$];
    logic [31:0] delivered [$];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00: return 32'h2008001B;
            32'h04: return 32'h00004820;
            32'h08: return 32'h00095080;
            32'h2C: return 32'h21290001;
            default: return (a * 32'd3) + 32'h1234_0000;
        endcase
    endfunction

    assign rom_rdata   = rom(rom_addr);
    assign rom_rdata_w = rom(rom_addr_w);

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFFFFFC)) dut_w (
        .clk(clk), .rst(rst_w), .fetch_en(fen_w),
        .rom_addr(rom_addr_w), .rom_rdata(rom_rdata_w),
        .inst_valid(inst_valid_w), .inst_ready(ready_w),
        .inst(inst_w), .inst_pc(inst_pc_w),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .count(count_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [63:0] head;
        head = (sb_q.size() != 0) ? sb_q[0] : 64'h0;
        check({tag, ".valid"}, 32'(inst_valid), 32'(sb_q.size() != 0));
        check({tag, ".count"}, 32'(count), 32'(sb_q.size()));
        check({tag, ".rom_addr"}, rom_addr, mpc);
        check({tag, ".inst"}, inst, head[31:0]);
        check({tag, ".inst_pc"}, inst_pc, head[63:32]);
    endtask

    // One clock of the main DUT: decide pop/push from the scoreboard, advance it, check at negedge.
    task automatic step(input string tag);
        bit do_pop, do_push, is_full;
        logic [63:0] dropped;
        do_pop  = (sb_q.size() != 0) && inst_ready;
        is_full = (sb_q.size() == DEPTH);
        do_push = fetch_en && !redirect_valid && (!is_full || do_pop);
        if (inst_valid && inst_ready) delivered.push_back(inst_pc);
        @(posedge clk);
        if (redirect_valid) begin
            sb_q.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (do_pop) dropped = sb_q.pop_front();
            if (do_push) begin
                sb_q.push_back({mpc, rom(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb_q.delete();
        delivered.delete();
        mpc = 32'h0;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        rst_w = 1'b1; fen_w = 1'b0; ready_w = 1'b0;
        mpc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check_state("por");
        rst = 1'b0;

        // T1 stream
        fetch_en = 1'b1; inst_ready = 1'b1;
        step("t1c1"); check("t1c1.inst", inst, 32'h2008001B); check("t1c1.pc", inst_pc, 32'h0);
        step("t1c2"); check("t1c2.inst", inst, 32'h00004820); check("t1c2.pc", inst_pc, 32'h4);
        step("t1c3"); check("t1c3.inst", inst, 32'h00095080); check("t1c3.pc", inst_pc, 32'h8);

        // T2 backpressure
        apply_reset();
        inst_ready = 1'b0;
        step("t2a");
        step("t2b");
        check("t2.count", 32'(count), 32'd2);
        check("t2.rom_addr", rom_addr, 32'h8);
        step("t2hold");
        check("t2hold.rom_addr", rom_addr, 32'h8);
        inst_ready = 1'b1;
        step("t2d0"); step("t2d1"); step("t2d2");
        check("t2.ndeliv", delivered.size(), 32'd3);
        if (delivered.size() == 3) begin
            check("t2.order0", delivered[0], 32'h0);
            check("t2.order1", delivered[1], 32'h4);
            check("t2.order2", delivered[2], 32'h8);
        end

        // T3 redirect from full
        inst_ready = 1'b0;
        step("t3fill0"); step("t3fill1");
        check("t3.full", 32'(count), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h2C;
        step("t3redir");
        check("t3.valid", 32'(inst_valid), 32'd0);
        check("t3.count", 32'(count), 32'd0);
        redirect_valid = 1'b0;
        step("t3new");
        check("t3.inst", inst, 32'h21290001);
        check("t3.pc", inst_pc, 32'h2C);

        // T4 alignment and redirect priority over push
        delivered.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h0000000E; inst_ready = 1'b1;
        step("t4redir");
        check("t4.rom_addr", rom_addr, 32'h0C);
        check("t4.count", 32'(count), 32'd0);
        check("t4.accepted", delivered.size(), 32'd1);
        redirect_valid = 1'b0;
        step("t4next");
        check("t4.pc", inst_pc, 32'h0C);

        // fetch_en=0 drains without new pushes
        inst_ready = 1'b0;
        step("fe_fill");
        fetch_en = 1'b0;
        inst_ready = 1'b1;
        step("fe_drain0"); step("fe_drain1"); step("fe_idle");

        // T6 async reset between clock edges
        fetch_en = 1'b1;
        step("t6run0"); step("t6run1");
        #2;
        rst = 1'b1;
        #1;
        check("t6.valid", 32'(inst_valid), 32'd0);
        check("t6.inst", inst, 32'h0);
        check("t6.inst_pc", inst_pc, 32'h0);
        check("t6.count", 32'(count), 32'd0);
        check("t6.rom_addr", rom_addr, 32'h0);

        // T5 wrap on the second instance
        check("t5.rst_addr", rom_addr_w, 32'hFFFFFFFC);
        @(negedge clk);
        rst_w = 1'b0; fen_w = 1'b1; ready_w = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t5.addr2", rom_addr_w, 32'h0);
        check("t5.head_pc", inst_pc_w, 32'hFFFFFFFC);
        @(posedge clk); @(negedge clk);
        check("t5.count", 32'(count_w), 32'd2);
        ready_w = 1'b1;
        @(posedge clk); @(negedge clk);
        check("t5.pc2", inst_pc_w, 32'h0);
        check("t5.inst2", inst_w, rom(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
